// File: rtl/operation_mac_bw16_inc3.sv
// operation_mac_bw16_inc3: ST/RD responder computing RES = IN0*IN1 + IN2 by
// shift-add over BW cycles. Optional saturating result: OPERATION_MAC_SATURATE_EN.
// Ports: CLK, RST (sync, active-high), ST start (rising edge), RD ready,
//        RES result, IN0 multiplicand, IN1 multiplier, IN2 addend.
module operation_mac_bw16_inc3 #(
  parameter int BW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ST,
  output logic          RD,
  output logic [BW-1:0] RES,
  input  logic [BW-1:0] IN0,
  input  logic [BW-1:0] IN1,
  input  logic [BW-1:0] IN2
);

  localparam int AW = 2*BW+1;
  localparam int CW = (BW > 1) ? $clog2(BW) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic          r_st_old;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_a;
  logic [BW-1:0] r_b;
  logic [AW-1:0] r_acc;

  logic          w_start;
  logic [BW-1:0] w_res;

  assign w_start = ST & ~r_st_old;

`ifdef OPERATION_MAC_SATURATE_EN
  logic w_ovf;
  assign w_ovf = |r_acc[AW-1:BW];
  assign w_res = w_ovf ? {BW{1'b1}} : r_acc[BW-1:0];
`else
  // Upper accumulator bits only matter for saturation.
  logic w_unused_hi;
  assign w_unused_hi = ^r_acc[AW-1:BW];
  assign w_res = r_acc[BW-1:0];
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_st_old <= 1'b0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      RD       <= 1'b1;
      RES      <= '0;
    end else begin
      r_st_old <= ST;
      // A start edge wins in any state, aborting work in flight.
      if (w_start) begin
        r_a     <= {{(AW-BW){1'b0}}, IN0};
        r_b     <= IN1;
        r_acc   <= {{(AW-BW){1'b0}}, IN2};
        r_cnt   <= '0;
        RD      <= 1'b0;
        r_state <= S_CALC;
      end else begin
        unique case (r_state)
          S_CALC: begin
            if (r_b[0]) r_acc <= r_acc + r_a;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(BW-1)) r_state <= S_DONE;
          end
          S_DONE: begin
            RES     <= w_res;
            RD      <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_operation_mac_bw16_inc3.sv
// tb_operation_mac_bw16_inc3: directed bench for the shift-add MAC responder.
// Drives ST/IN*, checks RD latency, result values, restart and reset abort.
module tb_operation_mac_bw16_inc3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ST;
  logic        RD;
  logic [15:0] RES;
  logic [15:0] IN0, IN1, IN2;

  int n_chk = 0;
  int n_err = 0;

  operation_mac_bw16_inc3 dut (
    .CLK (CLK),
    .RST (RST),
    .ST  (ST),
    .RD  (RD),
    .RES (RES),
    .IN0 (IN0),
    .IN1 (IN1),
    .IN2 (IN2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c);
    IN0 = a; IN1 = b; IN2 = c; ST = 1'b1;
    tick();
    ST = 1'b0;
  endtask

  // Count edges until RD=1, checking RES holds its old value meanwhile.
  task automatic wait_rd(input string tag, input logic [15:0] old_res,
                         output int n);
    int hold_bad;
    hold_bad = 0;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (RD) begin
        n = i;
        break;
      end
      if (RES !== old_res) hold_bad++;
    end
    chk({tag, "_res_hold"}, hold_bad, 0);
  endtask

  int lat;
  int rises;
  int first_rise;
  int rd_low;
  int res_bad;
  logic rd_prev;
  logic [15:0] exp2;

  initial begin
    RST = 1'b1; ST = 1'b0; IN0 = '0; IN1 = '0; IN2 = '0;
    tick();
    tick();
    RST = 1'b0;
    chk("rst_rd", RD, 1);
    chk("rst_res", RES, 0);

    // 1: 3*5+7
    start(16'd3, 16'd5, 16'd7);
    chk("t1_rd_busy", RD, 0);
    chk("t1_res_kept", RES, 0);
    wait_rd("t1", 16'h0000, lat);
    chk("t1_lat", lat, 17);
    chk("t1_res", RES, 16'h0016);

    // 2: all ones
`ifdef OPERATION_MAC_SATURATE_EN
    exp2 = 16'hFFFF;
`else
    exp2 = 16'h0000;
`endif
    start(16'hFFFF, 16'hFFFF, 16'hFFFF);
    chk("t2_rd_busy", RD, 0);
    wait_rd("t2", 16'h0016, lat);
    chk("t2_lat", lat, 17);
    chk("t2_res", RES, exp2);

    // 3: zero multiplicand
    start(16'h0000, 16'h1234, 16'h0000);
    wait_rd("t3", exp2, lat);
    chk("t3_lat", lat, 17);
    chk("t3_res", RES, 16'h0000);

    // 4: restart at E0+6
    start(16'd3, 16'd5, 16'd7);
    for (int i = 0; i < 5; i++) tick();
    chk("t4_busy_pre", RD, 0);
    start(16'd2, 16'd2, 16'd1);
    chk("t4_busy_restart", RD, 0);
    IN0 = 16'hAAAA; IN1 = 16'h5555; IN2 = 16'h1111;
    wait_rd("t4", 16'h0000, lat);
    chk("t4_lat", lat, 17);
    chk("t4_res", RES, 16'd5);

    // 5: reset at E0+8 aborts
    start(16'd3, 16'd5, 16'd7);
    for (int i = 0; i < 7; i++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t5_rd_rst", RD, 1);
    chk("t5_res_rst", RES, 0);
    rd_low = 0; res_bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!RD) rd_low++;
      if (RES !== 16'h0000) res_bad++;
    end
    chk("t5_no_rd_edge", rd_low, 0);
    chk("t5_res_zero", res_bad, 0);

    // 6: ST held high 40 cycles
    IN0 = 16'd4; IN1 = 16'd4; IN2 = 16'd0; ST = 1'b1;
    tick();
    chk("t6_rd_busy", RD, 0);
    rises = 0; first_rise = 0; rd_prev = RD;
    for (int i = 1; i < 60; i++) begin
      if (i == 40) ST = 1'b0;
      tick();
      if (RD && !rd_prev) begin
        rises++;
        if (first_rise == 0) first_rise = i;
      end
      rd_prev = RD;
    end
    chk("t6_rises", rises, 1);
    chk("t6_lat", first_rise, 17);
    chk("t6_res", RES, 16'd16);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
